regfile_write_arbiter: RTL

Shares the single write port of the 32 x 64-bit register file between two writeback requesters: req0 (ALU result) and req1 (load data from the multi-cycle memory path). It uses round-robin arbitration with valid/ready handshakes and registers the winning write into the register file's `RegWrite`/`RD`/`WriteData` inputs. A pending-write scoreboard tracks reserved destination registers so that issue logic can stall on read-after-write hazards.

---
 rtl/regfile_write_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single write port of the register file between two writeback
// requesters (req0: ALU result, req1: load data) using round-robin
// arbitration with valid/ready handshakes. The winning write is registered
// onto the register file's RegWrite/RD/WriteData inputs. A pending-write
// scoreboard tracks reserved destination registers so issue logic can stall
// on read-after-write hazards.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   req{0,1}_valid/rd/data   write request from requester 0/1
//   req{0,1}_ready           request accepted this cycle (combinational)
//   rsv_valid, rsv_rd        issue stage reserves a destination register
//   query_rs1, query_rs2     source registers to hazard-check
//   busy_rs1, busy_rs2       queried register has a write not yet visible
//   rf_we, rf_rd, rf_wdata   register file write port
//   pending                  scoreboard bitmap, bit i set while reg i reserved
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    input  logic [ADDR_W-1:0] query_rs1,
    input  logic [ADDR_W-1:0] query_rs2,
    output logic              busy_rs1,
    output logic              busy_rs2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [NREG-1:0]   pending
);

    // Index of the most recently accepted requester.
    logic              last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;

    // On a tie the requester other than the last winner is granted; a lone
    // valid requester always wins, so any valid request is accepted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    assign req0_ready = grant0 & reset;
    assign req1_ready = grant1 & reset;
    assign accept     = req0_ready | req1_ready;
    assign acc_rd     = req1_ready ? req1_rd   : req0_rd;
    assign acc_data   = req1_ready ? req1_data : req0_data;

    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;
        if (accept) begin
            last_grant_d = req1_ready;
            // A write to x0 is consumed but never reaches the register file.
            rf_we_d      = (acc_rd != '0);
            rf_rd_d      = acc_rd;
            rf_wdata_d   = acc_data;
        end
    end

    // Clear is applied before set so a same-edge reservation of the register
    // being written back keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (accept && (acc_rd != '0)) begin
            pending_d[acc_rd] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            pending_d[rsv_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            pending_q    <= pending_d;
        end
    end

    // The output-stage write is still invisible to readers until the
    // register file captures it, so it counts as busy alongside reservations.
    always_comb begin
        busy_rs1 = (query_rs1 != '0) &
                   (pending_q[query_rs1] | (rf_we_q & (rf_rd_q == query_rs1)));
        busy_rs2 = (query_rs2 != '0) &
                   (pending_q[query_rs2] | (rf_we_q & (rf_rd_q == query_rs2)));
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;

endmodule
